// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial I2S inputs and the sample-pair valid/ready stream of i2s_rx
interface i2s_rx_if;
  logic bclk;
  logic lrclk;
  logic data;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic out_valid;
  logic out_ready;
  logic overrun;
  logic frame_err;
  logic locked;
  modport master (
    input  bclk, lrclk, data, out_ready,
    output left_out, right_out, out_valid, overrun, frame_err, locked
  );
  modport slave (
    output bclk, lrclk, data, out_ready,
    input  left_out, right_out, out_valid, overrun, frame_err, locked
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: left-justified / Philips I2S receiver delivering stereo pairs on a valid/ready stream
module i2s_rx #(
  parameter int DELAY = 0
) (
  input logic clk,
  input logic rst,
  i2s_rx_if.master bus
);
  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;
  localparam logic [5:0] FIRST = 6'(DELAY);
  localparam logic [5:0] LAST = 6'(DELAY + 15);
  state_t state, state_nxt;
  logic [2:0] bclk_q, lrclk_q, data_q;
  logic lr_prev;
  logic [5:0] bit_idx;
  logic [15:0] sr_l, sr_r;
  logic rise, lr, d, lr_edge, fall_edge, rise_edge, full, in_win, load, err;
  logic [5:0] idx, off;
  assign rise = bclk_q[1] & ~bclk_q[2];
  assign lr = lrclk_q[1];
  assign d = data_q[1];
  assign lr_edge = rise && (lr != lr_prev);
  assign fall_edge = lr_edge && !lr;
  assign rise_edge = lr_edge && lr;
  assign idx = lr_edge ? 6'd0 : (bit_idx == 6'd63 ? bit_idx : bit_idx + 6'd1);
  assign off = idx - FIRST;
  assign in_win = off < 6'd16;
  assign full = bit_idx >= LAST;
  assign bus.locked = state != HUNT;
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    err = 1'b0;
    case (state)
      HUNT: state_nxt = fall_edge ? LEFT : HUNT;
      LEFT: if (rise_edge) begin
        state_nxt = full ? RIGHT : HUNT;
        err = !full;
      end
      RIGHT: if (fall_edge) begin
        state_nxt = LEFT;
        load = full;
        err = !full;
      end
      default: state_nxt = HUNT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q <= '0;
      lrclk_q <= '0;
      data_q <= '0;
      lr_prev <= 1'b0;
      bit_idx <= '0;
      sr_l <= '0;
      sr_r <= '0;
      bus.left_out <= '0;
      bus.right_out <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[1:0], bus.bclk};
      lrclk_q <= {lrclk_q[1:0], bus.lrclk};
      data_q <= {data_q[1:0], bus.data};
      if (rise) begin
        lr_prev <= lr;
        bit_idx <= idx;
        if (in_win && lr) sr_r <= {sr_r[14:0], d};
        if (in_win && !lr) sr_l <= {sr_l[14:0], d};
      end
      if (load) begin
        bus.left_out <= sr_l;
        bus.right_out <= sr_r;
      end
      bus.out_valid <= load | (bus.out_valid & ~bus.out_ready);
      bus.overrun <= load & bus.out_valid & ~bus.out_ready;
      bus.frame_err <= err;
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed vector bench for i2s_rx in left-justified and Philips modes
module tb_i2s_rx;
  localparam int HALF = 16;
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int nl;
    int nr;
    logic del;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic lrclk = 1'b0;
  logic data = 1'b0;
  logic out_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  int acc0 = 0, err0 = 0, ovr0 = 0, acc1 = 0;
  logic [15:0] last_l0 = '0, last_r0 = '0, last_l1 = '0, last_r1 = '0;
  int b_acc, b_err, b_ovr, b_acc1;
  vec_t vt [9];
  i2s_rx_if bus0 ();
  i2s_rx_if bus1 ();
  assign bus0.bclk = bclk;
  assign bus0.lrclk = lrclk;
  assign bus0.data = data;
  assign bus0.out_ready = out_ready;
  assign bus1.bclk = bclk;
  assign bus1.lrclk = lrclk;
  assign bus1.data = data;
  assign bus1.out_ready = out_ready;
  i2s_rx #(.DELAY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  i2s_rx #(.DELAY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.out_valid && bus0.out_ready) begin
        acc0 <= acc0 + 1;
        last_l0 <= bus0.left_out;
        last_r0 <= bus0.right_out;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        acc1 <= acc1 + 1;
        last_l1 <= bus1.left_out;
        last_r1 <= bus1.right_out;
      end
      if (bus0.frame_err) err0 <= err0 + 1;
      if (bus0.overrun) ovr0 <= ovr0 + 1;
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic send_bits(input logic lr, input logic [15:0] s, input int first, input int last, input int dly);
    for (int i = first; i <= last; i++) begin
      bclk = 1'b0;
      lrclk = lr;
      data = (i >= dly && i - dly < 16) ? s[15 - (i - dly)] : 1'b0;
      step(HALF);
      bclk = 1'b1;
      step(HALF);
    end
  endtask
  task automatic checkpoint(input int n);
    chk($sformatf("v%0d_accepts", n), 32'(acc0 - b_acc), {31'd0, vt[n].del});
    chk($sformatf("v%0d_frame_err", n), 32'(err0 - b_err), {31'd0, vt[n].err});
    if (vt[n].del) begin
      chk($sformatf("v%0d_left", n), {16'd0, last_l0}, {16'd0, vt[n].l});
      chk($sformatf("v%0d_right", n), {16'd0, last_r0}, {16'd0, vt[n].r});
    end
    chk($sformatf("v%0d_locked", n), {31'd0, bus0.locked}, 32'd1);
    b_acc = acc0;
    b_err = err0;
  endtask
  initial begin
    vt[0] = '{16'hA5C3, 16'h3C5A, 32, 32, 1'b1, 1'b0};
    vt[1] = '{16'hA5C3, 16'h3C5A, 32, 32, 1'b1, 1'b0};
    vt[2] = '{16'h8000, 16'h7FFF, 32, 32, 1'b1, 1'b0};
    vt[3] = '{16'hFFFF, 16'h0001, 16, 16, 1'b1, 1'b0};
    vt[4] = '{16'h1234, 16'hABCD, 10, 32, 1'b0, 1'b1};
    vt[5] = '{16'h0F0F, 16'hF0F0, 32, 32, 1'b1, 1'b0};
    vt[6] = '{16'h5555, 16'hAAAA, 32, 15, 1'b0, 1'b1};
    vt[7] = '{16'hC001, 16'h0FF0, 40, 70, 1'b1, 1'b0};
    vt[8] = '{16'h7E81, 16'h8118, 17, 17, 1'b1, 1'b0};
    step(4);
    chk("rst_left", {16'd0, bus0.left_out}, 32'd0);
    chk("rst_right", {16'd0, bus0.right_out}, 32'd0);
    chk("rst_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_overrun", {31'd0, bus0.overrun}, 32'd0);
    chk("rst_frame_err", {31'd0, bus0.frame_err}, 32'd0);
    chk("rst_locked", {31'd0, bus0.locked}, 32'd0);
    rst = 1'b0;
    step(2);
    b_acc = acc0;
    b_err = err0;
    send_bits(1'b1, 16'h0000, 0, 11, 0);
    step(8);
    chk("prime_accepts", 32'(acc0 - b_acc), 32'd0);
    chk("prime_frame_err", 32'(err0 - b_err), 32'd0);
    chk("prime_locked", {31'd0, bus0.locked}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      send_bits(1'b0, vt[i].l, 0, 1, 0);
      if (i > 0) checkpoint(i - 1);
      send_bits(1'b0, vt[i].l, 2, vt[i].nl - 1, 0);
      send_bits(1'b1, vt[i].r, 0, vt[i].nr - 1, 0);
    end
    send_bits(1'b0, 16'h0001, 0, 1, 0);
    checkpoint(8);
    out_ready = 1'b0;
    b_ovr = ovr0;
    send_bits(1'b0, 16'h0001, 2, 31, 0);
    send_bits(1'b1, 16'h0100, 0, 31, 0);
    for (int f = 2; f <= 3; f++) begin
      send_bits(1'b0, 16'(f), 0, 31, 0);
      send_bits(1'b1, 16'(f * 256), 0, 31, 0);
    end
    send_bits(1'b0, 16'h0000, 0, 1, 0);
    chk("ovr_pulses", 32'(ovr0 - b_ovr), 32'd2);
    chk("ovr_left", {16'd0, bus0.left_out}, 32'h0003);
    chk("ovr_right", {16'd0, bus0.right_out}, 32'h0300);
    chk("ovr_valid_held", {31'd0, bus0.out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_before_accept", {31'd0, bus0.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("ovr_valid_cleared", {31'd0, bus0.out_valid}, 32'd0);
    step(2);
    b_acc1 = acc1;
    send_bits(1'b0, 16'h0000, 2, 31, 0);
    send_bits(1'b1, 16'h0000, 0, 31, 0);
    for (int f = 0; f < 2; f++) begin
      send_bits(1'b0, 16'h8001, 0, 31, 1);
      send_bits(1'b1, 16'h7FFE, 0, 31, 1);
    end
    send_bits(1'b0, 16'h1111, 0, 1, 1);
    chk("philips_accepts", 32'(acc1 - b_acc1), 32'd3);
    chk("philips_left", {16'd0, last_l1}, 32'h8001);
    chk("philips_right", {16'd0, last_r1}, 32'h7FFE);
    send_bits(1'b0, 16'h1111, 2, 8, 0);
    rst = 1'b1;
    step(1);
    chk("midrst_left", {16'd0, bus0.left_out}, 32'd0);
    chk("midrst_right", {16'd0, bus0.right_out}, 32'd0);
    chk("midrst_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, bus0.frame_err}, 32'd0);
    chk("midrst_locked", {31'd0, bus0.locked}, 32'd0);
    rst = 1'b0;
    step(1);
    b_acc = acc0;
    b_err = err0;
    send_bits(1'b0, 16'h1111, 9, 31, 0);
    send_bits(1'b1, 16'h2222, 0, 31, 0);
    send_bits(1'b0, 16'h6B2D, 0, 31, 0);
    send_bits(1'b1, 16'h9E4F, 0, 31, 0);
    send_bits(1'b0, 16'h0000, 0, 1, 0);
    chk("midrst_accepts", 32'(acc0 - b_acc), 32'd1);
    chk("midrst_no_err", 32'(err0 - b_err), 32'd0);
    chk("midrst_cap_left", {16'd0, last_l0}, 32'h6B2D);
    chk("midrst_cap_right", {16'd0, last_r0}, 32'h9E4F);
    chk("midrst_relocked", {31'd0, bus0.locked}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
